// File: rtl/p4_axil_cfg_master.sv
// rtl/p4_axil_cfg_master.sv - AXI4-Lite initiator turning single-word register commands into bus transactions
// One transaction outstanding at a time; a bus-phase timeout guarantees every accepted command gets a response.
module p4_axil_cfg_master #(
    parameter int ADDR_W         = 13,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              axil_aclk,
    input  logic              axil_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, WR_AD, WR_B, RD_A, RD_R, RSP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              in_bus, limit, abort;

    // Outputs decode straight from registered state so an async reset clears them immediately.
    assign cmd_ready     = (state_q == IDLE) && axil_aresetn;
    assign m_axi_awvalid = (state_q == WR_AD) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR_AD) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_B);
    assign m_axi_arvalid = (state_q == RD_A);
    assign m_axi_rready  = (state_q == RD_R);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign rsp_valid     = (state_q == RSP);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;

    assign in_bus = (state_q == WR_AD) || (state_q == WR_B) || (state_q == RD_A) || (state_q == RD_R);
    assign limit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        if (in_bus && (TIMEOUT_CYCLES != 0)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = cmd_write ? WR_AD : RD_A;
                end
            end
            WR_AD: begin
                aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
                w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready);
                // Address/data handshakes are not completions, so the limit takes priority here.
                if (limit) begin
                    abort = 1'b1;
                end else if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (m_axi_bvalid) begin
                    rsp_resp_d    = m_axi_bresp;
                    rsp_rdata_d   = 32'h0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (limit) begin
                    abort = 1'b1;
                end
            end
            RD_A: begin
                if (limit) begin
                    abort = 1'b1;
                end else if (m_axi_arready) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                if (m_axi_rvalid) begin
                    rsp_resp_d    = m_axi_rresp;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (limit) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = 32'hDEADBEEF;
            state_d       = RSP;
        end
    end

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cnt_q         <= cnt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
endmodule

// File: doc/p4_axil_cfg_master.md
# p4_axil_cfg_master

AXI4-Lite initiator that turns single-word register commands into AXI4-Lite write and read transactions on the control port of the Vitis Net P4 pipeline. It sits between the testbench/host command source and the `s_axi_*` slave port of the P4 header-update wrapper. Its job is to program the match-action tables and to read back status and counters. It issues one outstanding transaction at a time and has a bounded-wait timeout, so a dead slave cannot hang the command source.

## Interface
Parameters:
- `ADDR_W`, default 13: AXI-Lite address width; also the width of `cmd_addr`.
- `TIMEOUT_CYCLES`, default 1024: bus-phase cycle limit before abort. 0 disables the timeout.

Ports:
- `axil_aclk`  in  1: the single clock.
- `axil_aresetn`  in  1: reset, asynchronous assert, active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W: register byte address.
- `cmd_wdata`  in  32: write data.
- `cmd_wstrb`  in  4: write strobes; ignored for reads.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumed.
- `rsp_rdata`  out  32: read data; 0 for writes.
- `rsp_resp`  out  2: BRESP or RRESP from the slave; 2'b10 on timeout.
- `rsp_timeout`  out  1: transaction was aborted by the timeout.
- `m_axi_awaddr`  out  ADDR_W
- `m_axi_awvalid`  out  1
- `m_axi_awready`  in  1
- `m_axi_wdata`  out  32
- `m_axi_wstrb`  out  4
- `m_axi_wvalid`  out  1
- `m_axi_wready`  in  1
- `m_axi_bresp`  in  2
- `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1
- `m_axi_araddr`  out  ADDR_W
- `m_axi_arvalid`  out  1
- `m_axi_arready`  in  1
- `m_axi_rdata`  in  32
- `m_axi_rresp`  in  2
- `m_axi_rvalid`  in  1
- `m_axi_rready`  out  1

## Operation
States:
- `IDLE`
- `WR_AD`: address and data phases of a write.
- `WR_B`: write response phase.
- `RD_A`: read address phase.
- `RD_R`: read data phase.
- `RSP`: response held for the command source.

Command acceptance:
- `cmd_ready = (state == IDLE) && axil_aresetn`.
- On acceptance, `cmd_addr`, `cmd_wdata` and `cmd_wstrb` are registered.
- Next state is `WR_AD` if `cmd_write`, otherwise `RD_A`.

Write path:
- `WR_AD`: `awvalid` and `wvalid` rise together on entry.
- Each one drops the cycle after its own handshake; the AW and W handshakes are independent and either may come first.
- Once both handshakes are complete, go to `WR_B`.
- `WR_B`: `bready = 1`. On `bvalid`, capture `bresp` into `rsp_resp`, set `rsp_rdata = 0`, go to `RSP`.

Read path:
- `RD_A`: `arvalid = 1`. On `arready`, go to `RD_R`.
- `RD_R`: `rready = 1`. On `rvalid`, capture `rdata` and `rresp` (data is captured even when RRESP is non-OKAY), go to `RSP`.

Response:
- `RSP`: `rsp_valid = 1`, with `rsp_*` held stable until `rsp_ready`, then go to `IDLE`.

Timeout:
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- The counter clears on command acceptance and increments every cycle spent in `WR_AD`, `WR_B`, `RD_A` or `RD_R`.
- When it reaches `TIMEOUT_CYCLES` with the transaction still incomplete:
  - all `m_axi_*valid` and `*ready` drop the next cycle;
  - go to `RSP` with `rsp_resp = 2'b10`, `rsp_timeout = 1`, `rsp_rdata = 32'hDEADBEEF`.
- A completion handshake in the same cycle as the limit wins: the transaction is a normal completion.
- Late `bvalid`/`rvalid` after an abort are ignored, because `bready`/`rready` stay 0 outside `WR_B`/`RD_R`.

## Timing
Reset:
- All outputs are 0 and `state = IDLE`.
- `cmd_ready` is 0 while `axil_aresetn` is low and 1 in the first cycle after release.
- Reset mid-transaction drops all valids immediately and no response is produced.

Latency, with command handshake at cycle 0:
- Cycle 1: `awvalid`/`wvalid` (or `arvalid`) high.
- Write with zero-wait slave: AW/W handshake at cycle 1, `bready` at cycle 2, `bvalid` at cycle 2, `rsp_valid` at cycle 3.
- Read: same shape: `arready` at cycle 1, `rvalid` at cycle 2, `rsp_valid` at cycle 3.
- Minimum spacing between command acceptances is 4 cycles, because of the mandatory return to `IDLE`.

AXI rules:
- A valid never drops before its handshake, except on timeout abort or reset.
- Address, data and strobes are stable while their valid is high.

## Test plan
- Write `addr=0x0040`, `data=0xA5A5_0001`, `wstrb=4'hF`, slave zero-wait with OKAY -> AW and W each seen once with those values; `rsp_valid` at cycle 3; `rsp_resp = 0`; `rsp_timeout = 0`.
- Write where the slave gives `wready` 3 cycles before `awready`, then BRESP = 2'b10 -> `wvalid` drops after its handshake while `awvalid` stays high; one B handshake; `rsp_resp = 2'b10`.
- Read `addr=0x0100`, slave returns `rdata=0x1234_5678` after 5 wait cycles on R -> `rsp_rdata = 0x1234_5678`; `rsp_resp = 0`; `rready` high throughout `RD_R`.
- Read with `TIMEOUT_CYCLES=16` and `arready` never asserted -> `arvalid` drops after 16 cycles; response has `rsp_timeout = 1`, `rsp_resp = 2'b10`, `rsp_rdata = 0xDEADBEEF`; a following command completes normally.
- `rsp_ready` held low 10 cycles while `cmd_valid` stays high -> `rsp_*` stable throughout; `cmd_ready = 0` until one cycle after the response handshake.
- `axil_aresetn` pulsed low during `WR_B` -> `bready`, `rsp_valid` and `cmd_ready` go to 0 at once; after release, `cmd_ready = 1` and no stale response is emitted.
